decoder_water_box: RTL and testbench

Drives the water-box animation from a 2-bit level code. It turns the code into a 3-bit fill count and a direction flag that step toward the requested level one count at a time. It sits downstream of the level source, on the display side of the water box. Its hysteresis matches encoder_water_box, so re-encoding `count_0_7`/`direction` always reproduces the accepted level once `settled`.

---
 rtl/decoder_water_box.sv | 188 ++++++++++++++++++
 tb/tb_decoder_water_box.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_water_box.sv
`default_nettype none
// ============================================================================
// Module      : decoder_water_box
// Description : Turns a 2-bit water-box level code into a 3-bit fill count
//               and a direction flag. The count moves one position at a time,
//               paced by the step tick, toward the window of the accepted
//               level. The window depends on the current direction, which
//               gives hysteresis matching encoder_water_box.
//               Optional feature macro: WATER_BOX_DEBOUNCE_EN. When defined,
//               a level code is accepted only after two consecutive matching
//               level_valid samples.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_water_box #(
    parameter int RESET_COUNT = 0,
    parameter int STEP_DIV    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] water_box,
    input  logic       level_valid,
    input  logic       step,
    output logic [2:0] count_0_7,
    output logic       direction,
    output logic       settled,
    output logic [1:0] target
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] C_LVL_C     = 2'b00;
    localparam logic [1:0] C_LVL_L     = 2'b01;
    localparam logic [1:0] C_LVL_M     = 2'b10;
    localparam logic [2:0] C_CNT_MIN   = 3'd0;
    localparam logic [2:0] C_CNT_MAX   = 3'd7;
    localparam logic [2:0] C_RST_COUNT = 3'(RESET_COUNT);
    localparam logic [3:0] C_DIV_LAST  = 4'(STEP_DIV - 1);

    // Registered state of the decoder
    logic [2:0] r_count;
    logic       r_direction;
    logic [1:0] r_target;
    logic [3:0] r_div;
    state_t     r_prev_state;

    // Combinational decode
    state_t     w_state;
    logic [2:0] w_win_lo;
    logic [2:0] w_win_hi;
    logic       w_reversal;
    logic [3:0] w_div_base;
    logic [2:0] w_count_next;
    logic       w_direction_next;
    logic [3:0] w_div_next;
    logic       w_accept;

    // Window of the accepted level; L and M windows shift with direction
    always_comb begin
        w_win_lo = C_CNT_MAX;
        w_win_hi = C_CNT_MAX;
        case (r_target)
            C_LVL_C: begin
                w_win_lo = C_CNT_MIN;
                w_win_hi = C_CNT_MIN;
            end
            C_LVL_L: begin
                w_win_lo = 3'd1;
                w_win_hi = r_direction ? 3'd2 : 3'd4;
            end
            C_LVL_M: begin
                w_win_lo = r_direction ? 3'd3 : 3'd5;
                w_win_hi = 3'd6;
            end
            default: begin
                w_win_lo = C_CNT_MAX;
                w_win_hi = C_CNT_MAX;
            end
        endcase
    end

    // Current state is decided purely from registered count/target/direction
    always_comb begin
        w_state = ST_IDLE;
        if (r_count < w_win_lo) begin
            w_state = ST_FILL;
        end else if (r_count > w_win_hi) begin
            w_state = ST_DRAIN;
        end
    end

    // Remember last cycle's state so a FILL<->DRAIN reversal can be detected
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev_state <= ST_IDLE;
        end else begin
            r_prev_state <= w_state;
        end
    end

    // Next count, direction and divider from the current state and step tick
    always_comb begin
        w_reversal = ((w_state == ST_FILL)  && (r_prev_state == ST_DRAIN)) ||
                     ((w_state == ST_DRAIN) && (r_prev_state == ST_FILL));
        w_div_base       = w_reversal ? 4'd0 : r_div;
        w_count_next     = r_count;
        w_direction_next = r_direction;
        w_div_next       = w_div_base;
        if (w_state == ST_IDLE) begin
            w_div_next = 4'd0;
        end else if (step) begin
            if (w_div_base >= C_DIV_LAST) begin
                w_div_next = 4'd0;
                if (w_state == ST_FILL) begin
                    w_direction_next = 1'b1;
                    if (r_count != C_CNT_MAX) begin
                        w_count_next = r_count + 3'd1;
                    end
                end else begin
                    w_direction_next = 1'b0;
                    if (r_count != C_CNT_MIN) begin
                        w_count_next = r_count - 3'd1;
                    end
                end
            end else begin
                w_div_next = w_div_base + 4'd1;
            end
        end
    end

    // Count, direction and divider registers; reset aborts any move in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count     <= C_RST_COUNT;
            r_direction <= 1'b1;
            r_div       <= 4'd0;
        end else begin
            r_count     <= w_count_next;
            r_direction <= w_direction_next;
            r_div       <= w_div_next;
        end
    end

`ifdef WATER_BOX_DEBOUNCE_EN
    logic [1:0] r_pend;
    logic       r_pend_valid;

    // A code is accepted only when it repeats the previous sample
    always_comb begin
        w_accept = level_valid && r_pend_valid && (water_box == r_pend);
    end

    // Pending sample register; every sample overwrites it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend       <= C_LVL_C;
            r_pend_valid <= 1'b0;
        end else if (level_valid) begin
            r_pend       <= water_box;
            r_pend_valid <= 1'b1;
        end
    end
`else
    // Every valid sample is accepted directly
    always_comb begin
        w_accept = level_valid;
    end
`endif

    // Accepted target level register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_target <= C_LVL_C;
        end else if (w_accept) begin
            r_target <= water_box;
        end
    end

    assign count_0_7 = r_count;
    assign direction = r_direction;
    assign settled   = (w_state == ST_IDLE);
    assign target    = r_target;

endmodule
`default_nettype wire

// File: tb/tb_decoder_water_box.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_water_box
// Description : Self-checking bench for decoder_water_box. Two instances:
//               dut_a with STEP_DIV=1 and dut_b with STEP_DIV=3, each with
//               its own stimulus, tracked by a level/window reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_water_box;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] wb_a, wb_b;
    logic       lv_a, lv_b, st_a, st_b;
    logic [2:0] cnt_a, cnt_b;
    logic       dir_a, dir_b, set_a, set_b;
    logic [1:0] tgt_a, tgt_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b
    int m_cnt[2];
    int m_dir[2];
    int m_tgt[2];
    int m_acc[2];
    int m_lmv[2];
    int m_pend[2];
    int m_pv[2];
    int m_div[2] = '{1, 3};

    always #5 clk = ~clk;

    decoder_water_box #(.RESET_COUNT(0), .STEP_DIV(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .water_box(wb_a), .level_valid(lv_a),
        .step(st_a), .count_0_7(cnt_a), .direction(dir_a), .settled(set_a),
        .target(tgt_a)
    );

    decoder_water_box #(.RESET_COUNT(0), .STEP_DIV(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .water_box(wb_b), .level_valid(lv_b),
        .step(st_b), .count_0_7(cnt_b), .direction(dir_b), .settled(set_b),
        .target(tgt_b)
    );

    function automatic int win_lo(int t, int d);
        case (t)
            0:       return 0;
            1:       return 1;
            2:       return (d != 0) ? 3 : 5;
            default: return 7;
        endcase
    endfunction

    function automatic int win_hi(int t, int d);
        case (t)
            0:       return 0;
            1:       return (d != 0) ? 2 : 4;
            2:       return 6;
            default: return 7;
        endcase
    endfunction

    // Re-encode a count/direction pair into the level whose window holds it
    function automatic int encode(int c, int d);
        for (int t = 0; t < 4; t++) begin
            if (c >= win_lo(t, d) && c <= win_hi(t, d)) return t;
        end
        return -1;
    endfunction

    function automatic int m_settled(int k);
        return (m_cnt[k] >= win_lo(m_tgt[k], m_dir[k]) &&
                m_cnt[k] <= win_hi(m_tgt[k], m_dir[k])) ? 1 : 0;
    endfunction

    // Advance the model of instance k by one clock edge
    task automatic model_step(input int k);
        int w, v, s, mv;
        w = (k == 0) ? int'(wb_a) : int'(wb_b);
        v = (k == 0) ? int'(lv_a) : int'(lv_b);
        s = (k == 0) ? int'(st_a) : int'(st_b);
        if (!rst_n) begin
            m_cnt[k] = 0; m_dir[k] = 1; m_tgt[k] = 0; m_acc[k] = 0;
            m_lmv[k] = 0; m_pend[k] = 0; m_pv[k] = 0;
            return;
        end
        if (m_cnt[k] < win_lo(m_tgt[k], m_dir[k]))      mv = 1;
        else if (m_cnt[k] > win_hi(m_tgt[k], m_dir[k])) mv = -1;
        else                                            mv = 0;
        if (mv == 0) begin
            m_acc[k] = 0;
        end else begin
            if (mv != m_lmv[k]) m_acc[k] = 0;
            if (s != 0) begin
                m_acc[k]++;
                if (m_acc[k] == m_div[k]) begin
                    m_cnt[k] = m_cnt[k] + mv;
                    if (m_cnt[k] > 7) m_cnt[k] = 7;
                    if (m_cnt[k] < 0) m_cnt[k] = 0;
                    m_dir[k] = (mv > 0) ? 1 : 0;
                    m_acc[k] = 0;
                end
            end
        end
        m_lmv[k] = mv;
`ifdef WATER_BOX_DEBOUNCE_EN
        if (v != 0) begin
            if (m_pv[k] != 0 && m_pend[k] == w) m_tgt[k] = w;
            m_pend[k] = w;
            m_pv[k]   = 1;
        end
`else
        if (v != 0) m_tgt[k] = w;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic set_target(input int k, input logic [1:0] t);
        if (k == 0) begin wb_a = t; lv_a = 1'b1; st_a = 1'b0; end
        else        begin wb_b = t; lv_b = 1'b1; st_b = 1'b0; end
        tick();
        tick();
        lv_a = 1'b0;
        lv_b = 1'b0;
    endtask

    task automatic do_steps(input int k, input int n);
        if (k == 0) st_a = 1'b1; else st_b = 1'b1;
        for (int i = 0; i < n; i++) tick();
        st_a = 1'b0;
        st_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (cnt_a !== 3'd0 || dir_a !== 1'b1 || tgt_a !== 2'd0 || set_a !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_a: got cnt=%0d dir=%0d tgt=%0d set=%0d required 0 1 0 1",
                     cnt_a, dir_a, tgt_a, set_a);
        end
        n_checks++;
        if (cnt_b !== 3'd0 || dir_b !== 1'b1 || tgt_b !== 2'd0 || set_b !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_b: got cnt=%0d dir=%0d tgt=%0d set=%0d required 0 1 0 1",
                     cnt_b, dir_b, tgt_b, set_b);
        end
        do_steps(0, 5);
        n_checks++;
        if (cnt_a !== 3'd0 || set_a !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_step: got cnt=%0d set=%0d required 0 1", cnt_a, set_a);
        end
    endtask

    task automatic test_fill_to_h();
        set_target(0, 2'd3);
        n_checks++;
        if (tgt_a !== 2'd3 || set_a !== 1'b0) begin
            n_fail++;
            $display("FAIL target_h: got tgt=%0d set=%0d required 3 0", tgt_a, set_a);
        end
        st_a = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_checks++;
            if (cnt_a !== 3'(i)) begin
                n_fail++;
                $display("FAIL fill_count: got %0d required %0d", cnt_a, i);
            end
        end
        n_checks++;
        if (set_a !== 1'b1 || dir_a !== 1'b1 || encode(int'(cnt_a), int'(dir_a)) != 3) begin
            n_fail++;
            $display("FAIL fill_settle: got set=%0d dir=%0d enc=%0d required 1 1 3",
                     set_a, dir_a, encode(int'(cnt_a), int'(dir_a)));
        end
        tick();
        st_a = 1'b0;
        n_checks++;
        if (cnt_a !== 3'd7) begin
            n_fail++;
            $display("FAIL saturate_7: got %0d required 7", cnt_a);
        end
    endtask

    task automatic test_drain_to_l();
        set_target(0, 2'd1);
        do_steps(0, 5);
        n_checks++;
        if (cnt_a !== 3'd4 || dir_a !== 1'b0 || set_a !== 1'b1 ||
            encode(int'(cnt_a), int'(dir_a)) != 1) begin
            n_fail++;
            $display("FAIL drain_l: got cnt=%0d dir=%0d set=%0d required 4 0 1",
                     cnt_a, dir_a, set_a);
        end
    endtask

    task automatic test_retarget_m();
        set_target(0, 2'd2);
        n_checks++;
        if (set_a !== 1'b0) begin
            n_fail++;
            $display("FAIL retarget_m_unsettled: got set=%0d required 0", set_a);
        end
        do_steps(0, 1);
        n_checks++;
        if (cnt_a !== 3'd5 || dir_a !== 1'b1 || set_a !== 1'b1) begin
            n_fail++;
            $display("FAIL retarget_m: got cnt=%0d dir=%0d set=%0d required 5 1 1",
                     cnt_a, dir_a, set_a);
        end
    endtask

    task automatic test_step_div();
        set_target(1, 2'd1);
        do_steps(1, 3);
        set_target(1, 2'd2);
        do_steps(1, 6);
        set_target(1, 2'd1);
        do_steps(1, 3);
        n_checks++;
        if (cnt_b !== 3'd2 || dir_b !== 1'b0 || set_b !== 1'b1) begin
            n_fail++;
            $display("FAIL div_setup: got cnt=%0d dir=%0d set=%0d required 2 0 1",
                     cnt_b, dir_b, set_b);
        end
        set_target(1, 2'd0);
        st_b = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_checks++;
            if (cnt_b !== 3'(2 - i / 3)) begin
                n_fail++;
                $display("FAIL div_drain: step %0d got %0d required %0d", i, cnt_b, 2 - i / 3);
            end
        end
        st_b = 1'b0;
        // Start filling toward H, leave one tick in the divider, then reverse
        set_target(1, 2'd3);
        do_steps(1, 4);
        set_target(1, 2'd0);
        do_steps(1, 2);
        n_checks++;
        if (cnt_b !== 3'd1) begin
            n_fail++;
            $display("FAIL div_reversal_hold: got %0d required 1", cnt_b);
        end
        do_steps(1, 1);
        n_checks++;
        if (cnt_b !== 3'd0 || dir_b !== 1'b0) begin
            n_fail++;
            $display("FAIL div_reversal_move: got cnt=%0d dir=%0d required 0 0", cnt_b, dir_b);
        end
    endtask

    task automatic test_debounce();
        logic [1:0] exp1, exp2;
`ifdef WATER_BOX_DEBOUNCE_EN
        exp1 = 2'd0; exp2 = 2'd0;
`else
        exp1 = 2'd3; exp2 = 2'd2;
`endif
        set_target(0, 2'd0);
        lv_a = 1'b1;
        wb_a = 2'd3;
        tick();
        n_checks++;
        if (tgt_a !== exp1) begin
            n_fail++;
            $display("FAIL deb_h: got %0d required %0d", tgt_a, exp1);
        end
        wb_a = 2'd2;
        tick();
        n_checks++;
        if (tgt_a !== exp2) begin
            n_fail++;
            $display("FAIL deb_m1: got %0d required %0d", tgt_a, exp2);
        end
        tick();
        lv_a = 1'b0;
        n_checks++;
        if (tgt_a !== 2'd2) begin
            n_fail++;
            $display("FAIL deb_m2: got %0d required 2", tgt_a);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            wb_a  = 2'($urandom_range(0, 3));
            wb_b  = 2'($urandom_range(0, 3));
            lv_a  = ($urandom_range(0, 9) == 0);
            lv_b  = ($urandom_range(0, 9) == 0);
            st_a  = 1'($urandom_range(0, 1));
            st_b  = 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if (int'(cnt_a) != m_cnt[0] || int'(dir_a) != m_dir[0] ||
                int'(tgt_a) != m_tgt[0] || int'(set_a) != m_settled(0)) begin
                n_fail++;
                $display("FAIL rand_a: cycle %0d got cnt=%0d dir=%0d tgt=%0d set=%0d required %0d %0d %0d %0d",
                         n, cnt_a, dir_a, tgt_a, set_a, m_cnt[0], m_dir[0], m_tgt[0], m_settled(0));
            end
            n_checks++;
            if (int'(cnt_b) != m_cnt[1] || int'(dir_b) != m_dir[1] ||
                int'(tgt_b) != m_tgt[1] || int'(set_b) != m_settled(1)) begin
                n_fail++;
                $display("FAIL rand_b: cycle %0d got cnt=%0d dir=%0d tgt=%0d set=%0d required %0d %0d %0d %0d",
                         n, cnt_b, dir_b, tgt_b, set_b, m_cnt[1], m_dir[1], m_tgt[1], m_settled(1));
            end
        end
        rst_n = 1'b1;
        lv_a = 1'b0; lv_b = 1'b0; st_a = 1'b0; st_b = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        wb_a = 2'd0; wb_b = 2'd0;
        lv_a = 1'b0; lv_b = 1'b0;
        st_a = 1'b0; st_b = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_dir[k] = 1; m_tgt[k] = 0; m_acc[k] = 0;
            m_lmv[k] = 0; m_pend[k] = 0; m_pv[k] = 0;
        end
        test_reset();
        test_fill_to_h();
        test_drain_to_l();
        test_retarget_m();
        test_step_div();
        test_debounce();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
